// File: rtl/bram_fifo.sv
// Valid/ready FIFO controller around an external dual-port synchronous-read block RAM.
// A two-entry skid buffer plus a read-data bypass hide the RAM read latency for full throughput.
module bram_fifo #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 8,
  parameter int DEPTH  = 1 << AWIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] enq_data,
  input  logic              enq_valid,
  output logic              enq_ready,
  output logic [DWIDTH-1:0] deq_data,
  output logic              deq_valid,
  input  logic              deq_ready,
  output logic [AWIDTH:0]   count,
  output logic [AWIDTH-1:0] ram_addr0,
  output logic [DWIDTH-1:0] ram_d0,
  output logic              ram_we0,
  output logic              ram_en0,
  output logic [AWIDTH-1:0] ram_addr1,
  output logic              ram_en1,
  output logic              ram_we1,
  output logic [DWIDTH-1:0] ram_d1,
  input  logic [DWIDTH-1:0] ram_q1
);

  localparam logic [AWIDTH:0]   LP_DEPTH = (AWIDTH + 1)'(DEPTH);
  localparam logic [AWIDTH-1:0] LP_LAST  = AWIDTH'(DEPTH - 1);

  logic [AWIDTH-1:0] r_wr_ptr;
  logic [AWIDTH-1:0] r_rd_ptr;
  logic [AWIDTH:0]   r_ram_count;
  logic              r_rd_pending;
  logic [1:0]        r_skid_count;
  logic [DWIDTH-1:0] r_skid0;
  logic [DWIDTH-1:0] r_skid1;

  logic              w_enq_ready;
  logic              w_enq_fire;
  logic              w_deq_valid;
  logic              w_deq_fire;
  logic              w_skid_empty;
  logic              w_rd_issue;
  logic              w_capture;
  logic [2:0]        w_occupancy;
  logic [1:0]        w_tail;
  logic [AWIDTH:0]   w_ram_count_next;

  function automatic logic [AWIDTH-1:0] f_next_ptr(input logic [AWIDTH-1:0] ptr);
    return (ptr == LP_LAST) ? '0 : ptr + AWIDTH'(1);
  endfunction

  assign w_enq_ready  = (r_ram_count < LP_DEPTH);
  assign w_enq_fire   = enq_valid && w_enq_ready;
  assign w_skid_empty = (r_skid_count == 2'd0);

  // With the skid buffer empty, a returning read word is presented straight from ram_q1.
  assign w_deq_valid  = !w_skid_empty || r_rd_pending;
  assign w_deq_fire   = w_deq_valid && deq_ready;

  // Words that will sit in the output stage after this cycle's pop; a new read needs a free slot.
  assign w_occupancy  = {1'b0, r_skid_count} + {2'b00, r_rd_pending} - {2'b00, w_deq_fire};
  assign w_rd_issue   = (r_ram_count != '0) && (w_occupancy < 3'd2);

  // A returning word consumed through the bypass is not stored.
  assign w_capture    = r_rd_pending && !(w_skid_empty && w_deq_fire);
  assign w_tail       = r_skid_count - {1'b0, w_deq_fire};

  // NOTE: always_comb assigns a default first so no path leaves the signal unassigned (no latch).
  always_comb begin
    w_ram_count_next = r_ram_count;
    if (w_enq_fire && !w_rd_issue) begin
      w_ram_count_next = r_ram_count + (AWIDTH + 1)'(1);
    end else if (!w_enq_fire && w_rd_issue) begin
      w_ram_count_next = r_ram_count - (AWIDTH + 1)'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_ram_count  <= '0;
      r_rd_pending <= 1'b0;
      r_skid_count <= 2'd0;
    end else begin
      if (w_enq_fire) begin
        r_wr_ptr <= f_next_ptr(r_wr_ptr);
      end
      if (w_rd_issue) begin
        r_rd_ptr <= f_next_ptr(r_rd_ptr);
      end
      r_ram_count  <= w_ram_count_next;
      r_rd_pending <= w_rd_issue;
      r_skid_count <= r_skid_count + {1'b0, r_rd_pending} - {1'b0, w_deq_fire};
    end
  end

  // NOTE: only the two skid registers are reset (so deq_data reads 0 after reset); the RAM array
  // itself is never cleared, the pointers make stale contents unreachable.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_skid0 <= '0;
      r_skid1 <= '0;
    end else begin
      if (w_deq_fire && !w_skid_empty) begin
        r_skid0 <= r_skid1;
      end
      if (w_capture) begin
        if (w_tail == 2'd0) begin
          r_skid0 <= ram_q1;
        end else begin
          r_skid1 <= ram_q1;
        end
      end
    end
  end

  assign enq_ready = w_enq_ready;
  assign deq_valid = w_deq_valid;
  assign deq_data  = (w_skid_empty && r_rd_pending) ? ram_q1 : r_skid0;
  assign count     = r_ram_count + (AWIDTH + 1)'(r_rd_pending) + (AWIDTH + 1)'(r_skid_count);

  assign ram_addr0 = r_wr_ptr;
  assign ram_d0    = enq_data;
  assign ram_we0   = w_enq_fire;
  assign ram_en0   = w_enq_fire;
  assign ram_addr1 = r_rd_ptr;
  assign ram_en1   = w_rd_issue;
  assign ram_we1   = 1'b0;
  assign ram_d1    = '0;

endmodule
